// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter onto a single downstream bus port.
// Holds one transaction at a time and aborts it with an error after a bounded wait.
module bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_valid_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_wstrb_i,
  input  logic        m0_instr_i,
  output logic        m0_ready_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_valid_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_wstrb_i,
  input  logic        m1_instr_i,
  output logic        m1_ready_o,
  output logic [31:0] m1_rdata_o,
  output logic        s_valid_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  output logic [3:0]  s_wstrb_o,
  output logic        s_instr_o,
  input  logic        s_ready_i,
  input  logic [31:0] s_rdata_i,
  output logic [1:0]  grant_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_CYCLES);
  localparam logic [31:0] ERR_DATA  = 32'hDEAD_BEEF;

  state_t      state_reg;
  logic [15:0] wait_cnt_reg;
  logic        last_grant_reg;  // 1: m1 was granted most recently
  logic        pick_m1;
  logic [15:0] wait_inc;
  logic        timeout_hit;

  // On a tie, the master that was not granted last wins.
  always_comb begin
    pick_m1 = m1_valid_i;
    if (m0_valid_i && m1_valid_i) begin
      pick_m1 = ~last_grant_reg;
    end
  end

  assign wait_inc    = wait_cnt_reg + 16'd1;
  assign timeout_hit = (wait_inc == TIMEOUT_W);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg      <= IDLE;
      wait_cnt_reg   <= 16'd0;
      last_grant_reg <= 1'b1;
      s_valid_o      <= 1'b0;
      s_addr_o       <= 32'd0;
      s_wdata_o      <= 32'd0;
      s_wstrb_o      <= 4'd0;
      s_instr_o      <= 1'b0;
      m0_ready_o     <= 1'b0;
      m1_ready_o     <= 1'b0;
      m0_rdata_o     <= 32'd0;
      m1_rdata_o     <= 32'd0;
      grant_o        <= 2'b00;
      err_o          <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (m0_valid_i || m1_valid_i) begin
            state_reg      <= BUSY;
            wait_cnt_reg   <= 16'd0;
            last_grant_reg <= pick_m1;
            grant_o        <= pick_m1 ? 2'b10 : 2'b01;
            s_valid_o      <= 1'b1;
            s_addr_o       <= pick_m1 ? m1_addr_i  : m0_addr_i;
            s_wdata_o      <= pick_m1 ? m1_wdata_i : m0_wdata_i;
            s_wstrb_o      <= pick_m1 ? m1_wstrb_i : m0_wstrb_i;
            s_instr_o      <= pick_m1 ? m1_instr_i : m0_instr_i;
          end
        end
        BUSY: begin
          // A completion in the same cycle as the timeout wins over the abort.
          if (s_ready_i) begin
            state_reg  <= RESP;
            s_valid_o  <= 1'b0;
            s_wstrb_o  <= 4'd0;
            m0_ready_o <= grant_o[0];
            m1_ready_o <= grant_o[1];
            m0_rdata_o <= grant_o[0] ? s_rdata_i : 32'd0;
            m1_rdata_o <= grant_o[1] ? s_rdata_i : 32'd0;
          end else if (timeout_hit) begin
            state_reg    <= RESP;
            wait_cnt_reg <= wait_inc;
            s_valid_o    <= 1'b0;
            m0_ready_o   <= grant_o[0];
            m1_ready_o   <= grant_o[1];
            m0_rdata_o   <= grant_o[0] ? ERR_DATA : 32'd0;
            m1_rdata_o   <= grant_o[1] ? ERR_DATA : 32'd0;
            err_o        <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_inc;
          end
        end
        RESP: begin
          state_reg  <= IDLE;
          grant_o    <= 2'b00;
          m0_ready_o <= 1'b0;
          m1_ready_o <= 1'b0;
          m0_rdata_o <= 32'd0;
          m1_rdata_o <= 32'd0;
          err_o      <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
